// File: rtl/rr_arb4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
interface rr_arb4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  // Arbiter side
  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_vld
  );

  // Client / resource side
  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_vld
  );
endinterface

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with maximum hold time under contention.
//
// state | meaning
// IDLE  | no grant active; arbitrate when en=1 and any req is set
// GRANT | owner holds the resource until it releases or is preempted
module rr_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb4_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // 4-to-2 priority encoder: index of the lowest set bit.
  function automatic logic [1:0] prio_enc4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if      (v[0]) idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  // Rotate so ptr lands at bit 0, encode, then rotate the index back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {r, r} >> p;
    rot = dbl[3:0];
    return prio_enc4(rot) + p;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;

  logic [1:0] pick;
  logic       release_c;
  logic       preempt_c;

  assign pick      = rr_pick(bus.req, ptr_q);
  assign release_c = ~bus.req[owner_q];
  assign preempt_c = (hold_q == HOLD_LAST) && ((bus.req & ~gnt_q) != 4'b0000);

  // State and grant registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      hold_q   <= 8'd0;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  // Next-state: arbitrate in IDLE, release/preempt or count hold in GRANT.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 4'b0000)) begin
          owner_d  = pick;
          gnt_d    = 4'b0001 << pick;
          gnt_id_d = pick;
          hold_d   = 8'd0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Release and preempt lead to the same next state, so no priority is needed.
        if (release_c || preempt_c) begin
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          ptr_d    = owner_q + 2'd1;
          state_d  = IDLE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = |gnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: three instances with MAX_HOLD of 8, 4 and 1.
module tb_rr_arb4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_arb4_if if8();
  rr_arb4_if if4();
  rr_arb4_if if1();

  rr_arb4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  rr_arb4 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  rr_arb4 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk8(input string name, input logic [3:0] eg, input logic [1:0] eid);
    checks++;
    if (if8.gnt !== eg || if8.gnt_id !== eid || if8.gnt_vld !== (eg != 4'b0000)) begin
      failures++;
      $display("FAIL %s: gnt=%b id=%0d vld=%b, required gnt=%b id=%0d vld=%b",
               name, if8.gnt, if8.gnt_id, if8.gnt_vld, eg, eid, eg != 4'b0000);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk8("reset_initial", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if8.en = 1'b1; if8.req = 4'b0100;
    step();
    chk8("reset_pre_grant", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("reset_async_mid_grant", 4'b0000, 2'd0);
    #1;
    rst_n = 1'b1;
    if8.req = 4'b1111;
    step();
    chk8("reset_ptr_zero", 4'b0001, 2'd0);
    if8.req = 4'b0000;
    step();
    chk8("reset_release", 4'b0000, 2'd0);
  endtask

  // ptr is 1 on entry (owner 0 released)
  task automatic test_single();
    if8.req = 4'b0100;
    step();
    chk8("single_grant", 4'b0100, 2'd2);
    if8.req = 4'b0000;
    step();
    chk8("single_release", 4'b0000, 2'd0);
    if8.req = 4'b1111;
    step();
    chk8("single_ptr3", 4'b1000, 2'd3);
    if8.req = 4'b0000;
    step();
    chk8("single_release3", 4'b0000, 2'd0);
  endtask

  // ptr is 0 on entry; grant 2 then release leaves ptr=3
  task automatic test_wrap();
    if8.req = 4'b0100;
    step();
    chk8("wrap_setup", 4'b0100, 2'd2);
    if8.req = 4'b0000;
    step();
    if8.req = 4'b0011;
    step();
    chk8("wrap_grant", 4'b0001, 2'd0);
    if8.req = 4'b0000;
    step();
    chk8("wrap_release", 4'b0000, 2'd0);
  endtask

  task automatic test_fair_rotation();
    logic [1:0] id;
    pulse_reset();
    if8.en = 1'b1; if8.req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      id = 2'(g % 4);
      for (int c = 0; c < 8; c++) begin
        chk8($sformatf("fair_g%0d_c%0d", g, c), 4'b0001 << id, id);
        step();
      end
      chk8($sformatf("fair_idle_%0d", g), 4'b0000, 2'd0);
      step();
    end
    if8.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_no_competitor_hold();
    if4.en = 1'b1; if4.req = 4'b0010;
    step();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (if4.gnt !== 4'b0010 || if4.gnt_id !== 2'd1 || if4.gnt_vld !== 1'b1) begin
        failures++;
        $display("FAIL hold4_c%0d: gnt=%b id=%0d vld=%b, required gnt=0010 id=1 vld=1",
                 c, if4.gnt, if4.gnt_id, if4.gnt_vld);
      end
      step();
    end
    checks++;
    if (dut4.hold_q !== 8'd3) begin
      failures++;
      $display("FAIL hold4_saturate: hold_cnt=%0d, required 3", dut4.hold_q);
    end
    // Saturated counter preempts as soon as a competitor appears.
    if4.req = 4'b0011;
    step();
    checks++;
    if (if4.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL hold4_preempt: gnt=%b, required 0000", if4.gnt);
    end
    step();
    checks++;
    if (if4.gnt !== 4'b0001 || if4.gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL hold4_next: gnt=%b id=%0d, required gnt=0001 id=0", if4.gnt, if4.gnt_id);
    end
    if4.req = 4'b0000;
    step();
  endtask

  task automatic test_max_hold_one();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0000;
    pulse_reset();
    if1.en = 1'b1; if1.req = 4'b1111;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (if1.gnt !== exp_seq[c]) begin
        failures++;
        $display("FAIL hold1_c%0d: gnt=%b, required %b", c, if1.gnt, exp_seq[c]);
      end
      step();
    end
    if1.req = 4'b0000;
    step();
  endtask

  task automatic test_enable();
    pulse_reset();
    if8.en = 1'b0; if8.req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      chk8($sformatf("en_low_c%0d", c), 4'b0000, 2'd0);
    end
    if8.en = 1'b1;
    step();
    chk8("en_raise", 4'b0001, 2'd0);
    if8.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk8($sformatf("en_drop_hold_c%0d", c), 4'b0001, 2'd0);
    end
    if8.req = 4'b1110;
    step();
    chk8("en_drop_release", 4'b0000, 2'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk8($sformatf("en_drop_no_new_c%0d", c), 4'b0000, 2'd0);
    end
    if8.req = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if8.en = 1'b0; if8.req = 4'b0000;
    if4.en = 1'b0; if4.req = 4'b0000;
    if1.en = 1'b0; if1.req = 4'b0000;
    test_reset();
    test_single();
    test_wrap();
    test_fair_rotation();
    test_no_competitor_hold();
    test_max_hold_one();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
